// File: rtl/myfilter_pkg.sv
// Shared filter-subsystem constants and types, including the dmem serial
// controller state encoding.
package myfilter_pkg;

    localparam int DATABITS                 = 16;
    localparam int CLK_PERIOD               = 10;
    localparam int DMEM_SCTRL_MAX_SDO_DELAY = 3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FLUSH,
        DONE
    } dmem_sctrl_state_t;

endpackage

// File: rtl/dmem_sctrl_shreg.sv
// Parallel-load, shift-left shift register with serial input; used for both
// the transmit and receive halves of the dmem serial controller.
module dmem_sctrl_shreg
    import myfilter_pkg::*;
#(
    parameter int W = DATABITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic         ser_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = {shreg_q[W-2:0], ser_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign q_o = shreg_q;

endmodule

// File: rtl/dmem_serial_ctrl_sva.sv
// Protocol assertions for dmem_serial_ctrl, attached to every instance by bind.
module dmem_serial_ctrl_sva #(
    parameter int CHAINLEN = 16
) (
    input logic clk,
    input logic rst,
`ifdef DMEM_SERIAL_CTRL_ABORT_EN
    input logic abort_in,
`endif
    input logic sde_out,
    input logic rx_valid_out,
    input logic ready_out,
    input logic busy_out
);

    localparam int RW = $clog2(CHAINLEN + 2);

    logic [RW-1:0] run_q;
    logic          runClr;

`ifdef DMEM_SERIAL_CTRL_ABORT_EN
    assign runClr = abort_in;
`else
    assign runClr = 1'b0;
`endif

    // Length of the current sde_out burst; aborted bursts are legitimately short.
    always_ff @(posedge clk) begin
        if (rst || runClr) begin
            run_q <= '0;
        end else if (sde_out) begin
            run_q <= run_q + 1'b1;
        end else begin
            run_q <= '0;
        end
    end

    a_sde_run: assert property (@(posedge clk) disable iff (rst)
        (!sde_out && run_q != '0) |-> (run_q == RW'(CHAINLEN)));
    a_sde_max: assert property (@(posedge clk) disable iff (rst)
        run_q <= RW'(CHAINLEN));
    a_rxv_pulse: assert property (@(posedge clk) disable iff (rst)
        rx_valid_out |=> !rx_valid_out);
    a_rdy_busy: assert property (@(posedge clk) disable iff (rst)
        !(ready_out && busy_out));

endmodule

bind dmem_serial_ctrl dmem_serial_ctrl_sva #(.CHAINLEN(CHAINLEN)) u_sva (
    .clk         (clk),
    .rst         (rst),
`ifdef DMEM_SERIAL_CTRL_ABORT_EN
    .abort_in    (abort_in),
`endif
    .sde_out     (sde_out),
    .rx_valid_out(rx_valid_out),
    .ready_out   (ready_out),
    .busy_out    (busy_out)
);

// File: rtl/dmem_serial_ctrl.sv
// Full-duplex serial master for the dmem scan chain: shifts tx_in out MSB-first
// while capturing sd_in. Optional abort support via DMEM_SERIAL_CTRL_ABORT_EN.
module dmem_serial_ctrl
    import myfilter_pkg::*;
#(
    parameter int CHAINLEN  = DATABITS,
    parameter int SDO_DELAY = 1
) (
    input  logic                clk,
    input  logic                rst,
`ifdef DMEM_SERIAL_CTRL_ABORT_EN
    input  logic                abort_in,
    output logic                abort_out,
`endif
    input  logic                start_in,
    output logic                ready_out,
    input  logic [CHAINLEN-1:0] tx_in,
    output logic [CHAINLEN-1:0] rx_out,
    output logic                rx_valid_out,
    output logic                sde_out,
    output logic                sd_out,
    input  logic                sd_in,
    output logic                busy_out
);

    localparam int CW = $clog2(CHAINLEN + 1);

    dmem_sctrl_state_t   state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CHAINLEN-1:0] rx_q, rx_d;
    logic [CHAINLEN-1:0] txWord, rxWord, rxNext;
    logic                txLoad, txShift, capEn, pipeFlush;

    dmem_sctrl_shreg #(.W(CHAINLEN)) u_txsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (txLoad),
        .shift_i(txShift),
        .ser_i  (1'b0),
        .data_i (tx_in),
        .q_o    (txWord)
    );

    dmem_sctrl_shreg #(.W(CHAINLEN)) u_rxsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (txLoad),
        .shift_i(capEn),
        .ser_i  (sd_in),
        .data_i ('0),
        .q_o    (rxWord)
    );

    // The final captured bit lands on the same edge that enters DONE, so
    // rx_out must be loaded from the receive register's next value.
    assign rxNext = capEn ? {rxWord[CHAINLEN-2:0], sd_in} : rxWord;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rx_d         = rx_q;
        txLoad       = 1'b0;
        txShift      = 1'b0;
        pipeFlush    = 1'b0;
        ready_out    = 1'b0;
        busy_out     = 1'b1;
        sde_out      = 1'b0;
        sd_out       = 1'b0;
        rx_valid_out = 1'b0;
        case (state_q)
            IDLE: begin
                ready_out = 1'b1;
                busy_out  = 1'b0;
                if (start_in) begin
                    txLoad  = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sde_out = 1'b1;
                sd_out  = txWord[CHAINLEN-1];
                txShift = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(CHAINLEN - 1)) begin
                    cnt_d   = '0;
                    state_d = (SDO_DELAY == 0) ? DONE : FLUSH;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(SDO_DELAY - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rx_valid_out = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef DMEM_SERIAL_CTRL_ABORT_EN
        if (abort_in && (state_q == SHIFT || state_q == FLUSH)) begin
            state_d   = IDLE;
            pipeFlush = 1'b1;
        end
`endif
        if (state_d == DONE) begin
            rx_d = rxNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
        end
    end

    assign rx_out = rx_q;

    // cap_en is sde_out aligned to when dmem's returned bit is actually valid.
    generate
        if (SDO_DELAY == 0) begin : gNoDelay
            assign capEn = sde_out;
        end else begin : gDelay
            logic [SDO_DELAY-1:0] capPipe_q;
            always_ff @(posedge clk) begin
                if (rst || pipeFlush) begin
                    capPipe_q <= '0;
                end else begin
                    capPipe_q[0] <= sde_out;
                    for (int i = 1; i < SDO_DELAY; i++) begin
                        capPipe_q[i] <= capPipe_q[i-1];
                    end
                end
            end
            assign capEn = capPipe_q[SDO_DELAY-1];
        end
    endgenerate

`ifdef DMEM_SERIAL_CTRL_ABORT_EN
    logic abort_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= pipeFlush;
        end
    end
    assign abort_out = abort_q;
`endif

endmodule

// File: doc/dmem_serial_ctrl.md
Name: dmem_serial_ctrl

Overview:
- Serial-port master for the dmem scan/serial interface. Drives dmem's sde_in/sd_in and captures dmem's sd_out.
- Accepts a parallel word on a valid/ready handshake and shifts it out MSB-first while shifting the returned chain contents in (full duplex).
- Presents the captured word with a one-cycle rx_valid pulse.
- Sits between the filter control/host logic and dmem; the bench uses it as the serial driver.

Parameters:
- CHAINLEN, default DATABITS: number of bits shifted per transaction (dmem serial chain length).
- SDO_DELAY, default 1: cycles from a shift edge until the corresponding bit is valid on dmem sd_out (range 0..3).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start_in  input  1  transaction request (valid)
- ready_out  output  1  controller idle and able to accept start_in
- tx_in  input  CHAINLEN  word to shift into dmem, sampled when start_in & ready_out
- rx_out  output  CHAINLEN  word captured from dmem sd_out
- rx_valid_out  output  1  one-cycle pulse, rx_out valid
- sde_out  output  1  serial enable to dmem sde_in
- sd_out  output  1  serial data to dmem sd_in
- sd_in  input  1  serial data from dmem sd_out
- busy_out  output  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0 except ready_out=1; rx_out=0; FSM=IDLE; counters cleared.
- FSM states:
  - IDLE: ready_out=1. On start_in: load tx shift register from tx_in, bit counter=0, go to SHIFT. start_in while not ready is ignored, not queued.
  - SHIFT: sde_out=1, sd_out=txsr[CHAINLEN-1], txsr shifts left by 1 each cycle. Counter increments. When counter==CHAINLEN-1, go to FLUSH. Exactly CHAINLEN cycles with sde_out=1.
  - FLUSH: sde_out=0, sd_out=0. Waits SDO_DELAY cycles while the last bits arrive. If SDO_DELAY=0, go directly to DONE.
  - DONE: rx_valid_out=1 for exactly one cycle, then go to IDLE. ready_out returns to 1 in the cycle after DONE.
- Capture: sde_out is delayed through an SDO_DELAY-stage pipeline to form cap_en. On each cap_en cycle, rxsr <= {rxsr[CHAINLEN-2:0], sd_in}, so the first received bit ends at the MSB. rx_out updates from rxsr on entry to DONE and holds until the next DONE.
- Latency: start accepted at cycle 0 → rx_valid_out at cycle CHAINLEN+SDO_DELAY+1.
- Back-to-back: start_in may be held high; the next transaction is accepted in the first IDLE cycle. Minimum gap between transactions is 1 IDLE cycle.
- Reset mid-transaction: FSM returns to IDLE next edge, sde_out drops immediately, no rx_valid_out, rx_out cleared.
- Counter width: $clog2(CHAINLEN+1); no wrap within a transaction.

Optional Feature:
- Macro: DMEM_SERIAL_CTRL_ABORT_EN
- With the macro: adds input abort_in (1 bit). abort_in=1 in SHIFT or FLUSH:
  - next edge: FSM→IDLE, sde_out=0, capture pipeline flushed;
  - no rx_valid_out; rx_out unchanged;
  - abort_out pulses 1 cycle.
  - abort_in in IDLE or DONE is ignored.
- Without the macro: no abort_in/abort_out ports; transactions always run to completion.

Decomposition:
- Add to myfilter_pkg:
  - dmem_sctrl_state_t enum {IDLE, SHIFT, FLUSH, DONE};
  - constant DMEM_SCTRL_MAX_SDO_DELAY=3.
  - DATABITS and CLK_PERIOD are reused from the package.
- One sub-module: dmem_sctrl_shreg, a parameterized CHAINLEN shift register with load, shift-left and serial-in. Instantiated twice (tx and rx).
- SVA bind file entries:
  - sde_out high exactly CHAINLEN consecutive cycles per transaction;
  - rx_valid_out one cycle wide;
  - ready_out and busy_out mutually exclusive.

Test Plan:
- Reset held 3 cycles then released → ready_out=1, sde_out=0, rx_valid_out=0, rx_out=0.
- CHAINLEN=16, SDO_DELAY=1; tx_in=16'hA5C3, dmem chain preloaded 16'h1234 → sd_out sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on 16 sde cycles; rx_valid_out at cycle 18 with rx_out=16'h1234; a follow-up read returns 16'hA5C3.
- start_in held high 3 transactions (tx 16'h0001, 16'h8000, 16'hFFFF) → 3 rx_valid_out pulses 19 cycles apart; each rx_out equals the previous tx_in.
- rst asserted at 8th SHIFT cycle → sde_out=0 next edge, no rx_valid_out, ready_out=1, rx_out=0.
- SDO_DELAY=0 and SDO_DELAY=3 builds, tx_in=16'h00FF → rx_valid_out at cycles 17 and 20; loopback value correct.
- With DMEM_SERIAL_CTRL_ABORT_EN: abort_in at 5th SHIFT cycle → abort_out pulse, no rx_valid_out, rx_out keeps prior value; next transaction completes normally.
